adc_spi_sampler: RTL

Front end that produces the `adc_data` stream consumed by the audio-processing top. It generates SPI reads of a 12-bit serial ADC (AD7476-style: CS low, 16 SCLK periods, 4 leading zeros, then 12 data bits MSB first) at a fixed sample rate. Each completed frame is presented as a parallel 12-bit sample with a one-cycle valid strobe. It is the writer side of the sample interface the processing chain reads.

---
 rtl/adc_spi_sampler_pkg.sv | 17 +
 rtl/adc_spi_sampler_if.sv | 22 ++
 rtl/adc_spi_sampler_tick_gen.sv | 27 ++
 rtl/adc_spi_sampler.sv | 131 +++++++++++++
 4 files changed

// File: rtl/adc_spi_sampler_pkg.sv
// Shared types and sizing for the ADC SPI sampler.
// Counter widths bound SCLK_HALF and QUIET_CYCLES to at most 2**HALF_CNT_W.
package adc_spi_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      SHIFT = 2'd2,
      QUIET = 2'd3
   } state_t;

   localparam int FRAME_BITS = 16;
   localparam int LEAD_BITS  = 4;
   localparam int BIT_CNT_W  = $clog2(FRAME_BITS);
   localparam int HALF_CNT_W = 8;

endpackage

// File: rtl/adc_spi_sampler_if.sv
// ADC pin bundle plus the parallel sample stream seen by the processing chain.
interface adc_spi_sampler_if #(
   parameter int DATA_WIDTH = 12
);
   logic                  adc_sdata;
   logic                  adc_cs_n;
   logic                  adc_sclk;
   logic [DATA_WIDTH-1:0] sample;
   logic                  sample_valid;
   logic                  lead_err;
   logic                  overrun;

   modport master (
      input  adc_sdata,
      output adc_cs_n, adc_sclk, sample, sample_valid, lead_err, overrun
   );

   modport slave (
      output adc_sdata,
      input  adc_cs_n, adc_sclk, sample, sample_valid, lead_err, overrun
   );
endinterface

// File: rtl/adc_spi_sampler_tick_gen.sv
// Sample-rate counter: free-runs 0..SAMPLE_DIV-1 while enabled, held at 0 otherwise.
// tick fires whenever the count is 0, so the first tick lands in the first enabled cycle.
module sample_tick_gen #(
   parameter int SAMPLE_DIV = 6250
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);
   localparam int W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst || !en) begin
         cnt_q <= '0;
      end else if (cnt_q == W'(SAMPLE_DIV - 1)) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + W'(1);
      end
   end

   assign tick = en && (cnt_q == '0);

endmodule

// File: rtl/adc_spi_sampler.sv
// SPI reader for an AD7476-style ADC: one 16-bit frame per rate tick, sample out with a 1-cycle strobe.
// Tick at T gives sample_valid at T+1+33*SCLK_HALF; all pin and stream outputs are registered.
module adc_spi_sampler
   import adc_spi_pkg::*;
#(
   parameter int SCLK_HALF    = 4,
   parameter int SAMPLE_DIV   = 6250,
   parameter int QUIET_CYCLES = 8,
   parameter int DATA_WIDTH   = 12
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   adc_spi_sampler_if.master  bus
);
   logic tick;

   sample_tick_gen #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .tick (tick)
   );

   state_t                  state_q, state_d;
   logic [HALF_CNT_W-1:0]   cnt_q, cnt_d;
   logic [BIT_CNT_W-1:0]    bit_q, bit_d;
   logic [FRAME_BITS-1:0]   shift_q, shift_d;
   logic [DATA_WIDTH-1:0]   sample_q, sample_d;
   logic                    cs_n_q, cs_n_d, sclk_q, sclk_d;
   logic                    valid_q, valid_d, lead_q, lead_d, ovr_q, ovr_d;
   logic                    half_done;

   assign half_done = (cnt_q == HALF_CNT_W'(SCLK_HALF - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         sample_q <= '0;
         cs_n_q   <= 1'b1;
         sclk_q   <= 1'b1;
         valid_q  <= 1'b0;
         lead_q   <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         sample_q <= sample_d;
         cs_n_q   <= cs_n_d;
         sclk_q   <= sclk_d;
         valid_q  <= valid_d;
         lead_q   <= lead_d;
         ovr_q    <= ovr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      sample_d = sample_q;
      cs_n_d   = cs_n_q;
      sclk_d   = sclk_q;
      valid_d  = 1'b0;
      lead_d   = 1'b0;
      ovr_d    = tick && (state_q != IDLE);

      case (state_q)
         IDLE: begin
            if (tick) begin
               state_d = SETUP;
               cs_n_d  = 1'b0;
               cnt_d   = '0;
            end
         end
         SETUP: begin
            if (half_done) begin
               state_d = SHIFT;
               sclk_d  = 1'b0;
               cnt_d   = '0;
               bit_d   = '0;
            end else begin
               cnt_d = cnt_q + HALF_CNT_W'(1);
            end
         end
         SHIFT: begin
            if (!half_done) begin
               cnt_d = cnt_q + HALF_CNT_W'(1);
            end else begin
               cnt_d = '0;
               // Capture on the cycle that drives the rising edge; data settled since the fall.
               if (!sclk_q) begin
                  sclk_d  = 1'b1;
                  shift_d = {shift_q[FRAME_BITS-2:0], bus.adc_sdata};
               end else if (bit_q == BIT_CNT_W'(FRAME_BITS - 1)) begin
                  state_d  = QUIET;
                  cs_n_d   = 1'b1;
                  sample_d = shift_q[DATA_WIDTH-1:0];
                  valid_d  = 1'b1;
                  lead_d   = |shift_q[FRAME_BITS-1 -: LEAD_BITS];
               end else begin
                  bit_d  = bit_q + BIT_CNT_W'(1);
                  sclk_d = 1'b0;
               end
            end
         end
         QUIET: begin
            if (cnt_q == HALF_CNT_W'(QUIET_CYCLES - 1)) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + HALF_CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.adc_cs_n     = cs_n_q;
   assign bus.adc_sclk     = sclk_q;
   assign bus.sample       = sample_q;
   assign bus.sample_valid = valid_q;
   assign bus.lead_err     = lead_q;
   assign bus.overrun      = ovr_q;

endmodule
